// File: rtl/buzzer_arbiter_if.sv
// Engine-side bundle for the buzzer arbiter: per-engine requests and waveforms in,
// owner/status and the arbitrated buzzer drive out.
interface buzzer_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] buz_in;
  logic             beep_req;
  logic [N_REQ-1:0] grant;
  logic             buzzer;
  logic             busy;
  logic             beep_active;

  modport master (
    output req, buz_in, beep_req,
    input  grant, buzzer, busy, beep_active
  );

  modport slave (
    input  req, buz_in, beep_req,
    output grant, buzzer, busy, beep_active
  );
endinterface

// File: rtl/buzzer_arbiter.sv
// Fixed-priority, non-preemptive owner of the single piano buzzer. A silent guard
// gap precedes every hand-over; a confirm beep may preempt any owner.
module buzzer_arbiter #(
  parameter int N_REQ       = 4,
  parameter int GAP_CYCLES  = 100000,
  parameter int BEEP_CYCLES = 5000000,
  parameter int BEEP_HALF   = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  buzzer_arbiter_if.slave  bus
);
  localparam int MAXC = (GAP_CYCLES > BEEP_CYCLES) ? GAP_CYCLES : BEEP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_OWN  = 2'd2;
  localparam logic [1:0] S_BEEP = 2'd3;

  localparam logic [CW-1:0] GAP_T  = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] BEEP_T = CW'(BEEP_CYCLES - 1);
  localparam logic [CW-1:0] HALF_T = CW'(BEEP_HALF - 1);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    cand_q, cand_d;
  logic [CW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [CW-1:0]    len_cnt_q, len_cnt_d;
  logic [CW-1:0]    tone_cnt_q, tone_cnt_d;
  logic             tone_q, tone_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             buzzer_q, buzzer_d;
  logic             busy_q, busy_d;
  logic             beep_q, beep_d;
  logic [IW-1:0]    low_idx;

  // Highest-priority requester is the lowest set bit.
  always_comb begin
    low_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (bus.req[i]) low_idx = IW'(i);
  end

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    gap_cnt_d  = gap_cnt_q;
    len_cnt_d  = len_cnt_q;
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;
    case (state_q)
      S_IDLE: begin
        if (bus.beep_req) begin
          state_d = S_BEEP; len_cnt_d = '0; tone_cnt_d = '0; tone_d = 1'b0;
        end else if (|bus.req) begin
          state_d = S_GAP; cand_d = low_idx; gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (bus.beep_req) begin
          state_d = S_BEEP; len_cnt_d = '0; tone_cnt_d = '0; tone_d = 1'b0;
        end else if (gap_cnt_q == GAP_T) begin
          state_d = bus.req[cand_q] ? S_OWN : S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_OWN: begin
        if (bus.beep_req) begin
          state_d = S_BEEP; len_cnt_d = '0; tone_cnt_d = '0; tone_d = 1'b0;
        end else if (!bus.req[cand_q]) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        // Further beep requests are deliberately not looked at here.
        if (len_cnt_q == BEEP_T) state_d = S_IDLE;
        else                     len_cnt_d = len_cnt_q + 1'b1;
        if (tone_cnt_q == HALF_T) begin
          tone_d = ~tone_q; tone_cnt_d = '0;
        end else begin
          tone_cnt_d = tone_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Outputs are registered from the next state so grant/buzzer change on the entry edge.
  always_comb begin
    grant_d  = (state_d == S_OWN) ? (ONE << cand_d) : '0;
    buzzer_d = 1'b0;
    if (state_d == S_OWN)       buzzer_d = bus.buz_in[cand_d];
    else if (state_d == S_BEEP) buzzer_d = tone_d;
    busy_d = (state_d != S_IDLE);
    beep_d = (state_d == S_BEEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cand_q     <= '0;
      gap_cnt_q  <= '0;
      len_cnt_q  <= '0;
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
      grant_q    <= '0;
      buzzer_q   <= 1'b0;
      busy_q     <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      gap_cnt_q  <= gap_cnt_d;
      len_cnt_q  <= len_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      grant_q    <= grant_d;
      buzzer_q   <= buzzer_d;
      busy_q     <= busy_d;
      beep_q     <= beep_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.buzzer      = buzzer_q;
  assign bus.busy        = busy_q;
  assign bus.beep_active = beep_q;
endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed scenarios plus random traffic, each cycle compared with a behavioural
// model of ownership, guard gap and beep timing.
module tb_buzzer_arbiter;
  localparam int N     = 4;
  localparam int GAP   = 4;
  localparam int BLEN  = 20;
  localparam int BHALF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  buzzer_arbiter_if #(.N_REQ(N)) bus ();

  buzzer_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .BEEP_CYCLES(BLEN), .BEEP_HALF(BHALF))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 idle, 1 waiting out the gap, 2 owned, 3 beeping.
  int m_mode = 0;
  int m_cand = 0;
  int m_gap_left = 0;
  int m_age = 0;
  logic [N-1:0] e_grant = '0;
  logic e_buz = 1'b0, e_busy = 1'b0, e_beep = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cand = 0; m_gap_left = 0; m_age = 0;
    e_grant = '0; e_buz = 1'b0; e_busy = 1'b0; e_beep = 1'b0;
  endtask

  task automatic model_step();
    logic [N-1:0] r;
    int prev;
    r = bus.req;
    prev = m_mode;
    if (prev != 3 && bus.beep_req) begin
      m_mode = 3; m_age = 0;
    end else if (prev == 0) begin
      if (r != 0) begin
        for (int i = 0; i < N; i++) if (r[i]) begin m_cand = i; break; end
        m_gap_left = GAP + 1;
        m_mode = 1;
      end
    end else if (prev == 1) begin
      m_gap_left--;
      if (m_gap_left == 0) m_mode = r[m_cand] ? 2 : 0;
    end else if (prev == 2) begin
      if (!r[m_cand]) m_mode = 0;
    end else begin
      m_age++;
      if (m_age == BLEN) m_mode = 0;
    end
    e_grant = (m_mode == 2) ? (N'(1) << m_cand) : '0;
    e_buz   = (m_mode == 2) ? bus.buz_in[m_cand] :
              (m_mode == 3) ? 1'((m_age / BHALF) % 2) : 1'b0;
    e_busy  = (m_mode != 0);
    e_beep  = (m_mode == 3);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".grant"},  32'(bus.grant),       32'(e_grant));
    chk({tag, ".buzzer"}, 32'(bus.buzzer),      32'(e_buz));
    chk({tag, ".busy"},   32'(bus.busy),        32'(e_busy));
    chk({tag, ".beep"},   32'(bus.beep_active), 32'(e_beep));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    bus.buz_in = N'($urandom);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic pulse_beep(input string tag);
    bus.beep_req = 1'b1;
    tick(tag);
    bus.beep_req = 1'b0;
  endtask

  initial begin
    int cnt;
    bus.req = '0; bus.buz_in = '0; bus.beep_req = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // 1: single requester, guard gap then 1-cycle-lag passthrough
    bus.req = 4'b0010;
    ticks("s1", 5);
    chk("s1.gap_grant", 32'(bus.grant), 32'h0);
    tick("s1");
    chk("s1.own_grant", 32'(bus.grant), 32'h2);
    ticks("s1", 8);

    // 2: higher priority ignored while owned; hand-over after a gap
    bus.req = 4'b0000; tick("s2");
    bus.req = 4'b1000; ticks("s2", 7);
    bus.req = 4'b1001; ticks("s2", 5);
    chk("s2.held", 32'(bus.grant), 32'h8);
    bus.req = 4'b0001;
    ticks("s2", 6);
    chk("s2.still_gap", 32'(bus.grant), 32'h0);
    tick("s2");
    chk("s2.handover", 32'(bus.grant), 32'h1);

    // 3: simultaneous requests and a late higher-priority request during GAP
    bus.req = 4'b0000; tick("s3");
    bus.req = 4'b0110; ticks("s3", 2);
    bus.req = 4'b0111; ticks("s3", 8);
    chk("s3.cand", 32'(bus.grant), 32'h2);

    // 4/5: beep preempts owner, is not restarted, owner re-arbitrates afterwards
    bus.req = 4'b0100; ticks("s4", 10);
    chk("s4.own", 32'(bus.grant), 32'h4);
    pulse_beep("s4");
    chk("s4.preempt", 32'(bus.grant), 32'h0);
    cnt = 0;
    while (bus.beep_active && cnt < 100) begin
      cnt++;
      bus.beep_req = (cnt == 5);
      tick("s4");
    end
    bus.beep_req = 1'b0;
    chk("s5.beep_len", 32'(cnt), 32'd20);
    ticks("s4", 8);
    chk("s4.regrant", 32'(bus.grant), 32'h4);

    bus.req = 4'b0000; ticks("s5", 2);
    bus.req = 4'b0001;
    pulse_beep("s5");
    chk("s5.beep_first", 32'(bus.beep_active), 32'h1);
    ticks("s5", 25);

    // 6: asynchronous reset in the middle of a beep
    bus.req = 4'b0000; ticks("s6", 8);
    pulse_beep("s6");
    ticks("s6", 6);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("s6.async");
    @(negedge clk);
    rst_n = 1'b1;
    ticks("s6", 4);
    chk("s6.idle", 32'(bus.busy), 32'h0);

    // Random traffic: sticky requests, rare beeps, random waveforms
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 15) == 0) bus.req = N'($urandom);
      bus.beep_req = ($urandom_range(0, 59) == 0);
      tick("rnd");
    end
    bus.beep_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
